// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause / screen-dim controller.
package pause_pkg;

    // User-pause state machine; hold requests never enter it.
    typedef enum logic [1:0] {
        StRun,
        StPaused,
        StFading,
        StDimmed
    } pause_state_e;

    // Width needed to hold a shift amount in 0..max_dim.
    function automatic int unsigned dim_w(input int unsigned max_dim);
        return (max_dim < 1) ? 1 : $clog2(max_dim + 1);
    endfunction

endpackage

// File: rtl/pause_video_dim.sv
// One ce_pix register stage for the video bus, with each colour channel shifted right by the
// currently applied dim level. Sync and blank pass through the same stage to stay aligned.
module pause_video_dim #(
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned LVL_W   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ce_pix_i,
    input  logic [LVL_W-1:0]     level_i,
    input  logic [3*COLOR_W-1:0] rgb_i,
    input  logic                 hs_i,
    input  logic                 vs_i,
    input  logic                 hblank_i,
    input  logic                 vblank_i,
    output logic [3*COLOR_W-1:0] rgb_o,
    output logic                 hs_o,
    output logic                 vs_o,
    output logic                 hblank_o,
    output logic                 vblank_o
);

    logic [3*COLOR_W-1:0] rgb_d, rgb_q;
    logic [3:0]           sync_d, sync_q;

    // Per-channel dimming shifter.
    always_comb begin
        rgb_d = '0;
        for (int c = 0; c < 3; c++) begin
            rgb_d[c*COLOR_W +: COLOR_W] = rgb_i[c*COLOR_W +: COLOR_W] >> level_i;
        end
        sync_d = {hs_i, vs_i, hblank_i, vblank_i};
    end

    // Video register stage, advanced only on pixel enables.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q  <= '0;
            sync_q <= '0;
        end else if (ce_pix_i) begin
            rgb_q  <= rgb_d;
            sync_q <= sync_d;
        end
    end

    assign rgb_o    = rgb_q;
    assign hs_o     = sync_q[3];
    assign vs_o     = sync_q[2];
    assign hblank_o = sync_q[1];
    assign vblank_o = sync_q[0];

endmodule

// File: rtl/pause_dimmer.sv
// Pause merger and idle screen dimmer. A user pause toggle and any number of hold requests
// produce one registered pause; a long user pause fades the picture in steps, with the applied
// level changed only at the start of vblank so no frame is ever split.
module pause_dimmer
    import pause_pkg::*;
#(
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned NUM_HOLD    = 2,
    parameter int unsigned DIM_CYCLES  = 240000000,
    parameter int unsigned STEP_CYCLES = 2400000,
    parameter int unsigned MAX_DIM     = 1
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        pause_btn,
    input  logic [NUM_HOLD-1:0]         hold_req,
    input  logic                        activity,
    input  logic                        ce_pix,
    input  logic [3*COLOR_W-1:0]        rgb_in,
    input  logic                        hs_in,
    input  logic                        vs_in,
    input  logic                        hblank_in,
    input  logic                        vblank_in,
    output logic                        pause,
    output logic                        user_paused,
    output logic [dim_w(MAX_DIM)-1:0]   dim_level,
    output logic [3*COLOR_W-1:0]        rgb_out,
    output logic                        hs_out,
    output logic                        vs_out,
    output logic                        hblank_out,
    output logic                        vblank_out
);

    localparam int unsigned DimW   = dim_w(MAX_DIM);
    localparam int unsigned TimerW = $clog2(DIM_CYCLES + 1);
    localparam int unsigned StepW  = $clog2(STEP_CYCLES + 1);

    localparam logic [TimerW-1:0] LastTimer = TimerW'(DIM_CYCLES - 1);
    localparam logic [StepW-1:0]  LastStep  = StepW'(STEP_CYCLES - 1);
    localparam logic [DimW-1:0]   MaxLevel  = DimW'(MAX_DIM);

    logic              btn_q, btn_old_q;
    logic              toggle;
    logic              pause_d, pause_q;
    logic              user_paused_q;
    pause_state_e      state_q;
    logic [TimerW-1:0] timer_q;
    logic [StepW-1:0]  step_q;
    logic [DimW-1:0]   target_q;
    logic [DimW-1:0]   target_inc;
    logic              vblank_q;
    logic [DimW-1:0]   dim_level_q;

    // Button is registered once, then compared with its previous sample for a clean edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q     <= 1'b0;
            btn_old_q <= 1'b0;
        end else begin
            btn_q     <= pause_btn;
            btn_old_q <= btn_q;
        end
    end

    assign toggle     = btn_q & ~btn_old_q;
    assign target_inc = target_q + DimW'(1);

    // Merged pause follows the toggled user state in the same cycle the toggle lands.
    always_comb begin
        pause_d = (toggle ? ~user_paused_q : user_paused_q) | (|hold_req);
    end

    // Registered pause to the core.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_d;
        end
    end

    // User pause FSM with idle timer and fade step counter; toggle beats activity.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StRun;
            user_paused_q <= 1'b0;
            timer_q       <= '0;
            step_q        <= '0;
            target_q      <= '0;
        end else if (toggle) begin
            if (state_q == StRun) begin
                state_q       <= StPaused;
                user_paused_q <= 1'b1;
            end else begin
                state_q       <= StRun;
                user_paused_q <= 1'b0;
            end
            timer_q  <= '0;
            step_q   <= '0;
            target_q <= '0;
        end else if (activity && (state_q != StRun)) begin
            // Player is back: full brightness and restart the idle wait, still paused.
            state_q  <= StPaused;
            timer_q  <= '0;
            step_q   <= '0;
            target_q <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    timer_q  <= '0;
                    step_q   <= '0;
                    target_q <= '0;
                end
                StPaused: begin
                    if (timer_q == LastTimer) begin
                        step_q   <= '0;
                        target_q <= DimW'(1);
                        state_q  <= (MaxLevel == DimW'(1)) ? StDimmed : StFading;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StFading: begin
                    if (step_q == LastStep) begin
                        step_q   <= '0;
                        target_q <= target_inc;
                        if (target_inc == MaxLevel) begin
                            state_q <= StDimmed;
                        end
                    end else begin
                        step_q <= step_q + StepW'(1);
                    end
                end
                StDimmed: begin
                    target_q <= MaxLevel;
                end
                default: begin
                    state_q  <= StRun;
                    target_q <= '0;
                end
            endcase
        end
    end

    // Applied level only moves at the pixel-enabled rising edge of vblank.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q    <= 1'b0;
            dim_level_q <= '0;
        end else if (ce_pix) begin
            vblank_q <= vblank_in;
            if (vblank_in && !vblank_q) begin
                dim_level_q <= target_q;
            end
        end
    end

    pause_video_dim #(
        .COLOR_W (COLOR_W),
        .LVL_W   (DimW)
    ) u_video (
        .clk_i    (clk_sys),
        .rst_ni   (reset_n),
        .ce_pix_i (ce_pix),
        .level_i  (dim_level_q),
        .rgb_i    (rgb_in),
        .hs_i     (hs_in),
        .vs_i     (vs_in),
        .hblank_i (hblank_in),
        .vblank_i (vblank_in),
        .rgb_o    (rgb_out),
        .hs_o     (hs_out),
        .vs_o     (vs_out),
        .hblank_o (hblank_out),
        .vblank_o (vblank_out)
    );

    assign pause       = pause_q;
    assign user_paused = user_paused_q;
    assign dim_level   = dim_level_q;

endmodule

// File: tb/tb_pause_dimmer.sv
// Bench for pause_dimmer: closed-form reference model plus video scoreboard, a vector table for
// hold-pause merging, and directed sequences for fade, wake, toggle/activity and reset.
module tb_pause_dimmer;

    localparam int unsigned CW    = 8;
    localparam int unsigned NH    = 2;
    localparam int unsigned DIMC  = 16;
    localparam int unsigned STEPC = 4;
    localparam int unsigned MAXD  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pause_btn = 1'b0;
    logic [NH-1:0] hold_req = '0;
    logic          activity = 1'b0;
    logic          ce_pix = 1'b0;
    logic [23:0]   rgb_in = '0;
    logic          hs_in = 1'b0, vs_in = 1'b0, hblank_in = 1'b0, vblank_in = 1'b0;
    logic          pause, user_paused;
    logic [1:0]    dim_level;
    logic [23:0]   rgb_out;
    logic          hs_out, vs_out, hblank_out, vblank_out;

    pause_dimmer #(
        .COLOR_W     (CW),
        .NUM_HOLD    (NH),
        .DIM_CYCLES  (DIMC),
        .STEP_CYCLES (STEPC),
        .MAX_DIM     (MAXD)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (rst_n),
        .pause_btn   (pause_btn),
        .hold_req    (hold_req),
        .activity    (activity),
        .ce_pix      (ce_pix),
        .rgb_in      (rgb_in),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .hblank_in   (hblank_in),
        .vblank_in   (vblank_in),
        .pause       (pause),
        .user_paused (user_paused),
        .dim_level   (dim_level),
        .rgb_out     (rgb_out),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .hblank_out  (hblank_out),
        .vblank_out  (vblank_out)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic        rgb_fixed_en = 1'b1;
    logic [23:0] rgb_fixed = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
        end
    endtask

    // Video timing source: ce_pix every 4th cycle, 64-cycle frames, vblank rises at phase 48.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc       = cyc + 1;
            ce_pix    = (cyc % 4) == 0;
            vblank_in = (cyc % 64) >= 48;
            vs_in     = ((cyc % 64) >= 52) && ((cyc % 64) < 60);
            hblank_in = (cyc % 16) >= 12;
            hs_in     = ((cyc % 16) >= 8) && ((cyc % 16) < 12);
            rgb_in    = rgb_fixed_en ? rgb_fixed : 24'($urandom);
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [23:0] rgb;
        logic [3:0]  sync;
    } vid_t;

    vid_t        vid_q[$];
    vid_t        ev;
    logic        m_b1, m_b2, m_up, m_pause, m_vb;
    logic [1:0]  m_lvl;
    int unsigned m_idle;
    wire         m_tog = m_b1 & ~m_b2;

    // Target level as a closed form of cycles spent user-paused without activity.
    function automatic logic [1:0] tgt(input logic up, input int unsigned idle);
        int unsigned s;
        if (!up || idle < DIMC) return 2'd0;
        s = 1 + (idle - DIMC) / STEPC;
        if (s > MAXD) s = MAXD;
        return 2'(s);
    endfunction

    function automatic logic [23:0] shr(input logic [23:0] v, input logic [1:0] l);
        logic [7:0] r, g, b;
        r = v[23:16] >> l;
        g = v[15:8] >> l;
        b = v[7:0] >> l;
        return {r, g, b};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b1    <= 1'b0;
            m_b2    <= 1'b0;
            m_up    <= 1'b0;
            m_pause <= 1'b0;
            m_vb    <= 1'b0;
            m_lvl   <= 2'd0;
            m_idle  <= 0;
            vid_q.delete();
        end else begin
            m_b1    <= pause_btn;
            m_b2    <= m_b1;
            m_pause <= (m_tog ? ~m_up : m_up) | (|hold_req);
            if (m_tog) begin
                m_up   <= ~m_up;
                m_idle <= 0;
            end else if (m_up && activity) begin
                m_idle <= 0;
            end else if (m_up && m_idle < 1000000) begin
                m_idle <= m_idle + 1;
            end
            if (ce_pix) begin
                m_vb <= vblank_in;
                if (vblank_in && !m_vb) m_lvl <= tgt(m_up, m_idle);
                vid_q.push_back({shr(rgb_in, m_lvl), hs_in, vs_in, hblank_in, vblank_in});
            end
        end
    end

    // Continuous comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("pause", pause, m_pause);
            check("user_paused", user_paused, m_up);
            check("dim_level", dim_level, m_lvl);
            if (vid_q.size() > 0) begin
                ev = vid_q.pop_front();
                check("rgb_out", rgb_out, ev.rgb);
                check("sync_out", {hs_out, vs_out, hblank_out, vblank_out}, ev.sync);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Advance to the given phase of the 64-cycle frame (always moves at least one cycle).
    task automatic wait_phase(input int unsigned p);
        tick(1);
        while ((cyc % 64) != p) tick(1);
    endtask

    typedef struct {
        logic [1:0]  hold;
        logic [23:0] rgb;
        logic        exp_pause;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{2'b00, 24'hAA5533, 1'b0};
        tbl[1] = '{2'b01, 24'hFFFFFF, 1'b1};
        tbl[2] = '{2'b10, 24'h010203, 1'b1};
        tbl[3] = '{2'b11, 24'h804020, 1'b1};
        tbl[4] = '{2'b00, 24'h7F7F7F, 1'b0};
        tbl[5] = '{2'b10, 24'h000000, 1'b1};

        // Reset state.
        rst_n = 1'b0;
        tick(3);
        check("rst_pause", pause, 1'b0);
        check("rst_user_paused", user_paused, 1'b0);
        check("rst_dim_level", dim_level, 2'd0);
        check("rst_rgb_out", rgb_out, 24'h0);
        check("rst_sync_out", {hs_out, vs_out, hblank_out, vblank_out}, 4'h0);
        rst_n = 1'b1;
        tick(4);

        // Hold requests merge into pause one cycle later; video passes unshifted.
        for (int i = 0; i < 6; i++) begin
            hold_req  = tbl[i].hold;
            rgb_fixed = tbl[i].rgb;
            tick(1);
            check("tbl_pause", pause, tbl[i].exp_pause);
            tick(8);
            check("tbl_rgb", rgb_out, tbl[i].rgb);
        end

        // Long hold while running: no dimming, no user pause.
        hold_req = 2'b10;
        tick(1);
        check("hold_pause", pause, 1'b1);
        tick(99);
        check("hold_pause_long", pause, 1'b1);
        check("hold_dim", dim_level, 2'd0);
        check("hold_user", user_paused, 1'b0);
        hold_req = 2'b00;
        tick(1);
        check("hold_release", pause, 1'b0);

        // Fade: toggle at phase 28 -> target 1 before the vblank rise, target 2 just after.
        rgb_fixed = 24'hFFFFFF;
        wait_phase(28);
        pause_btn = 1'b1;
        tick(1);
        check("btn_pause_n1", pause, 1'b0);
        tick(1);
        check("btn_pause_n2", pause, 1'b1);
        check("btn_user_n2", user_paused, 1'b1);
        pause_btn = 1'b0;
        wait_phase(47);
        check("fade_pre_vblank_lvl", dim_level, 2'd0);
        check("fade_pre_vblank_rgb", rgb_out, 24'hFFFFFF);
        wait_phase(56);
        check("fade_lvl1", dim_level, 2'd1);
        check("fade_rgb_7f", rgb_out, 24'h7F7F7F);
        wait_phase(56);
        check("fade_lvl2", dim_level, 2'd2);
        check("fade_rgb_3f", rgb_out, 24'h3F3F3F);

        // Activity while dimmed: still paused, bright at next vblank, fades again later.
        wait_phase(40);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        check("wake_user", user_paused, 1'b1);
        wait_phase(56);
        check("wake_lvl0", dim_level, 2'd0);
        check("wake_rgb", rgb_out, 24'hFFFFFF);
        wait_phase(56);
        check("refade_lvl2", dim_level, 2'd2);

        // Toggle and activity in the same cycle during fading: toggle wins.
        wait_phase(10);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        wait_phase(27);
        pause_btn = 1'b1;
        tick(1);
        activity = 1'b1;
        tick(1);
        activity  = 1'b0;
        pause_btn = 1'b0;
        check("tog_act_user", user_paused, 1'b0);
        check("tog_act_pause", pause, 1'b0);
        wait_phase(56);
        check("tog_act_lvl", dim_level, 2'd0);

        // Reset while fading at level 1.
        wait_phase(28);
        pause_btn = 1'b1;
        tick(2);
        pause_btn = 1'b0;
        wait_phase(49);
        check("pre_rst_lvl", dim_level, 2'd1);
        rst_n = 1'b0;
        #1;
        check("arst_pause", pause, 1'b0);
        check("arst_user", user_paused, 1'b0);
        check("arst_lvl", dim_level, 2'd0);
        check("arst_rgb", rgb_out, 24'h0);
        check("arst_sync", {hs_out, vs_out, hblank_out, vblank_out}, 4'h0);
        rgb_fixed = 24'h123456;
        tick(3);
        rst_n = 1'b1;
        tick(8);
        check("post_rst_rgb", rgb_out, 24'h123456);
        check("post_rst_user", user_paused, 1'b0);

        // Random pixels over a couple of full frames for the scoreboard.
        rgb_fixed_en = 1'b0;
        tick(130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
